riscv_mem_arbiter: RTL and testbench

RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

---
 rtl/riscv_mem_arbiter_pkg.sv | 21 ++
 rtl/riscv_arb_timeout_cnt.sv | 39 +++
 rtl/riscv_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package riscv_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StImem = 2'd1,
      StDmem = 2'd2
   } arb_state_e;

   // Returned to the fetch stage when an instruction read times out.
   localparam logic [31:0] NopInstr    = 32'h0000_0013;
   localparam logic [3:0]  ByteSelWord = 4'b1111;

   typedef struct packed {
      logic        wr_en;
      logic [3:0]  byte_sel;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/riscv_arb_timeout_cnt.sv
// Per-transaction watchdog for the memory arbiter; only built with RISCV_ARB_TIMEOUT_EN.
`ifdef RISCV_ARB_TIMEOUT_EN
module riscv_arb_timeout_cnt #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic busy_i,
   input  logic clear_i,
   output logic expired_o
);

   localparam int unsigned CntW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'((LIMIT > 0) ? LIMIT - 1 : 0);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!busy_i || clear_i) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires in the last allowed busy cycle so completion lands on this edge.
   assign expired_o = busy_i && (cnt_q == CntLast);

endmodule
`endif

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates fetch and memory-stage requests onto one shared memory port (data side wins).
// Optional watchdog: define RISCV_ARB_TIMEOUT_EN to force completion after TIMEOUT_CYCLES.
module riscv_mem_arbiter
   import riscv_mem_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_arb_imem_req,
   input  logic [31:0] i_arb_imem_addr,
   output logic [31:0] o_arb_imem_rdata,
   output logic        o_arb_imem_ack,
   input  logic        i_arb_dmem_req,
   input  logic        i_arb_dmem_wr_en,
   input  logic [31:0] i_arb_dmem_addr,
   input  logic [31:0] i_arb_dmem_wdata,
   input  logic [3:0]  i_arb_dmem_byte_sel,
   output logic [31:0] o_arb_dmem_rdata,
   output logic        o_arb_dmem_ack,
   output logic        o_arb_mem_req,
   output logic        o_arb_mem_wr_en,
   output logic [31:0] o_arb_mem_addr,
   output logic [31:0] o_arb_mem_wdata,
   output logic [3:0]  o_arb_mem_byte_sel,
   input  logic [31:0] i_arb_mem_rdata,
   input  logic        i_arb_mem_ack,
   output logic        o_arb_stall_f,
   output logic        o_arb_stall_m,
   output logic        o_arb_err
);

   arb_state_e  state_q, state_d;
   mem_cmd_t    cmd_q, cmd_d;
   logic        imem_ack_q, imem_ack_d;
   logic        dmem_ack_q, dmem_ack_d;
   logic [31:0] imem_rdata_q, imem_rdata_d;
   logic [31:0] dmem_rdata_q, dmem_rdata_d;

   logic        busy;
   logic        timed_out;
   logic        mem_done;
   logic [31:0] resp_data;
   logic        grant_imem;
   logic        grant_dmem;

   assign busy     = (state_q != StIdle);
   assign mem_done = busy & (i_arb_mem_ack | timed_out);

`ifdef RISCV_ARB_TIMEOUT_EN
   logic expired;
   logic err_q;

   riscv_arb_timeout_cnt #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk_i     (i_clk),
      .rst_i     (i_rst),
      .busy_i    (busy),
      .clear_i   (mem_done),
      .expired_o (expired)
   );

   // A real ack arriving in the expiry cycle wins over the forced completion.
   assign timed_out = expired & ~i_arb_mem_ack;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         err_q <= 1'b0;
      end else if (timed_out) begin
         err_q <= 1'b1;
      end
   end

   assign o_arb_err = err_q;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timed_out          = 1'b0;
   assign o_arb_err          = 1'b0;
`endif

   always_comb begin
      if (i_arb_mem_ack) begin
         resp_data = i_arb_mem_rdata;
      end else if (state_q == StImem) begin
         resp_data = NopInstr;
      end else begin
         resp_data = 32'h0;
      end
   end

   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      imem_ack_d   = 1'b0;
      dmem_ack_d   = 1'b0;
      imem_rdata_d = imem_rdata_q;
      dmem_rdata_d = dmem_rdata_q;
      grant_imem   = 1'b0;
      grant_dmem   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (i_arb_dmem_req) begin
               grant_dmem = 1'b1;
            end else if (i_arb_imem_req) begin
               grant_imem = 1'b1;
            end
         end
         StImem: begin
            if (mem_done) begin
               imem_ack_d   = 1'b1;
               imem_rdata_d = resp_data;
               state_d      = StIdle;
               if (i_arb_dmem_req) begin
                  grant_dmem = 1'b1;
               end else if (i_arb_imem_req) begin
                  grant_imem = 1'b1;
               end
            end
         end
         StDmem: begin
            if (mem_done) begin
               dmem_ack_d   = 1'b1;
               dmem_rdata_d = resp_data;
               state_d      = StIdle;
               if (i_arb_imem_req) begin
                  grant_imem = 1'b1;
               end else if (i_arb_dmem_req) begin
                  grant_dmem = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Granting on the completion edge keeps the port busy with no idle bubble.
      if (grant_dmem) begin
         state_d        = StDmem;
         cmd_d.wr_en    = i_arb_dmem_wr_en;
         cmd_d.byte_sel = i_arb_dmem_byte_sel;
         cmd_d.addr     = i_arb_dmem_addr;
         cmd_d.wdata    = i_arb_dmem_wdata;
      end else if (grant_imem) begin
         state_d        = StImem;
         cmd_d.wr_en    = 1'b0;
         cmd_d.byte_sel = ByteSelWord;
         cmd_d.addr     = i_arb_imem_addr;
         cmd_d.wdata    = 32'h0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= StIdle;
         cmd_q        <= '0;
         imem_ack_q   <= 1'b0;
         dmem_ack_q   <= 1'b0;
         imem_rdata_q <= 32'h0;
         dmem_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         imem_ack_q   <= imem_ack_d;
         dmem_ack_q   <= dmem_ack_d;
         imem_rdata_q <= imem_rdata_d;
         dmem_rdata_q <= dmem_rdata_d;
      end
   end

   assign o_arb_mem_req      = busy;
   assign o_arb_mem_wr_en    = cmd_q.wr_en;
   assign o_arb_mem_addr     = cmd_q.addr;
   assign o_arb_mem_wdata    = cmd_q.wdata;
   assign o_arb_mem_byte_sel = cmd_q.byte_sel;

   assign o_arb_imem_ack   = imem_ack_q;
   assign o_arb_imem_rdata = imem_rdata_q;
   assign o_arb_dmem_ack   = dmem_ack_q;
   assign o_arb_dmem_rdata = dmem_rdata_q;

   assign o_arb_stall_f = i_arb_imem_req & ~imem_ack_q;
   assign o_arb_stall_m = i_arb_dmem_req & ~dmem_ack_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a latency-programmable shared-memory model.
module tb_riscv_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic        dmem_req;
   logic        dmem_wr_en;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_byte_sel;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        mem_req;
   logic        mem_wr_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_sel;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ack = 1'b0;
   logic        stall_f;
   logic        stall_m;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   int mem_lat   = 2;
   bit hold_ack  = 1'b0;
   bit force_ack = 1'b0;
   int mcnt      = 0;

   always #5 clk = ~clk;

   riscv_mem_arbiter #(
      .TIMEOUT_CYCLES (4)
   ) dut (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_arb_imem_req      (imem_req),
      .i_arb_imem_addr     (imem_addr),
      .o_arb_imem_rdata    (imem_rdata),
      .o_arb_imem_ack      (imem_ack),
      .i_arb_dmem_req      (dmem_req),
      .i_arb_dmem_wr_en    (dmem_wr_en),
      .i_arb_dmem_addr     (dmem_addr),
      .i_arb_dmem_wdata    (dmem_wdata),
      .i_arb_dmem_byte_sel (dmem_byte_sel),
      .o_arb_dmem_rdata    (dmem_rdata),
      .o_arb_dmem_ack      (dmem_ack),
      .o_arb_mem_req       (mem_req),
      .o_arb_mem_wr_en     (mem_wr_en),
      .o_arb_mem_addr      (mem_addr),
      .o_arb_mem_wdata     (mem_wdata),
      .o_arb_mem_byte_sel  (mem_byte_sel),
      .i_arb_mem_rdata     (mem_rdata),
      .i_arb_mem_ack       (mem_ack),
      .o_arb_stall_f       (stall_f),
      .o_arb_stall_m       (stall_m),
      .o_arb_err           (err)
   );

   // Memory: acks after mem_lat request cycles; returns a fixed word for 0x100.
   always @(negedge clk) begin
      if (rst || !mem_req) begin
         mcnt    = 0;
         mem_ack = force_ack;
      end else begin
         if (mem_ack) mcnt = 0;
         mcnt    = mcnt + 1;
         mem_ack = force_ack || (!hold_ack && (mcnt == mem_lat));
      end
      mem_rdata = (mem_addr == 32'h100) ? 32'h0050_0093 : {mem_addr[15:0], 16'hC0DE};
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bit quiet = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!mem_req && !imem_ack && !dmem_ack) begin
            quiet = 1'b1;
            break;
         end
         tick();
      end
      check_eq("drain_idle", {31'h0, quiet}, 32'h1);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      imem_req      = 1'b0;
      imem_addr     = 32'h0;
      dmem_req      = 1'b0;
      dmem_wr_en    = 1'b0;
      dmem_addr     = 32'h0;
      dmem_wdata    = 32'h0;
      dmem_byte_sel = 4'h0;
      tick();
      tick();
      check_eq("rst_mem_req", mem_req, 32'h0);
      check_eq("rst_byte_sel", mem_byte_sel, 32'h0);
      check_eq("rst_imem_ack", imem_ack, 32'h0);
      check_eq("rst_err", err, 32'h0);
      rst = 1'b0;
      tick();

      // Fetch 0x100, memory answers two cycles after the grant.
      mem_lat   = 2;
      imem_req  = 1'b1;
      imem_addr = 32'h100;
      tick();
      check_eq("f_mem_req", mem_req, 32'h1);
      check_eq("f_mem_addr", mem_addr, 32'h100);
      check_eq("f_wr_en", mem_wr_en, 32'h0);
      check_eq("f_byte_sel", mem_byte_sel, 32'hF);
      check_eq("f_stall_f", stall_f, 32'h1);
      tick();
      check_eq("f_no_ack_yet", imem_ack, 32'h0);
      tick();
      check_eq("f_ack", imem_ack, 32'h1);
      check_eq("f_rdata", imem_rdata, 32'h0050_0093);
      check_eq("f_stall_f_low", stall_f, 32'h0);
      imem_req = 1'b0;
      tick();
      check_eq("f_ack_one_cycle", imem_ack, 32'h0);
      check_eq("f_rdata_hold", imem_rdata, 32'h0050_0093);
      check_eq("f_stall_after", stall_f, 32'h0);
      drain();

      // Simultaneous fetch and load: data side first, fetch follows with no gap.
      imem_req   = 1'b1;
      imem_addr  = 32'h104;
      dmem_req   = 1'b1;
      dmem_wr_en = 1'b0;
      dmem_addr  = 32'h2000;
      tick();
      check_eq("c_addr_dmem", mem_addr, 32'h2000);
      check_eq("c_wr_en", mem_wr_en, 32'h0);
      check_eq("c_stall_f", stall_f, 32'h1);
      check_eq("c_stall_m", stall_m, 32'h1);
      tick();
      check_eq("c_stall_f_hold", stall_f, 32'h1);
      tick();
      check_eq("c_dmem_ack", dmem_ack, 32'h1);
      check_eq("c_dmem_rdata", dmem_rdata, 32'h2000_C0DE);
      check_eq("c_no_bubble", mem_req, 32'h1);
      check_eq("c_addr_imem", mem_addr, 32'h104);
      check_eq("c_imem_bsel", mem_byte_sel, 32'hF);
      check_eq("c_stall_f_dmem", stall_f, 32'h1);
      check_eq("c_stall_m_low", stall_m, 32'h0);
      dmem_req = 1'b0;
      tick();
      check_eq("c_dmem_ack_once", dmem_ack, 32'h0);
      check_eq("c_imem_busy", mem_req, 32'h1);
      tick();
      check_eq("c_imem_ack", imem_ack, 32'h1);
      check_eq("c_imem_rdata", imem_rdata, 32'h0104_C0DE);
      check_eq("c_dmem_rdata_hold", dmem_rdata, 32'h2000_C0DE);
      imem_req = 1'b0;
      drain();

      // Partial-word store.
      dmem_req      = 1'b1;
      dmem_wr_en    = 1'b1;
      dmem_addr     = 32'h2004;
      dmem_wdata    = 32'hDEAD_BEEF;
      dmem_byte_sel = 4'b0011;
      tick();
      check_eq("s_wr_en", mem_wr_en, 32'h1);
      check_eq("s_byte_sel", mem_byte_sel, 32'h3);
      check_eq("s_wdata", mem_wdata, 32'hDEAD_BEEF);
      check_eq("s_addr", mem_addr, 32'h2004);
      tick();
      check_eq("s_no_ack_yet", dmem_ack, 32'h0);
      tick();
      check_eq("s_ack", dmem_ack, 32'h1);
      check_eq("s_stall_m", stall_m, 32'h0);
      dmem_req      = 1'b0;
      dmem_wr_en    = 1'b0;
      dmem_byte_sel = 4'h0;
      tick();
      check_eq("s_ack_single", dmem_ack, 32'h0);
      drain();

      // Reset mid-load, then a stray ack after release.
      hold_ack   = 1'b1;
      dmem_req   = 1'b1;
      dmem_wr_en = 1'b0;
      dmem_addr  = 32'h2008;
      tick();
      check_eq("r_granted", mem_req, 32'h1);
      tick();
      rst      = 1'b1;
      dmem_req = 1'b0;
      hold_ack = 1'b0;
      #1;
      check_eq("r_mem_req", mem_req, 32'h0);
      check_eq("r_mem_addr", mem_addr, 32'h0);
      check_eq("r_wr_en", mem_wr_en, 32'h0);
      check_eq("r_dmem_rdata", dmem_rdata, 32'h0);
      check_eq("r_imem_rdata", imem_rdata, 32'h0);
      tick();
      tick();
      rst       = 1'b0;
      force_ack = 1'b1;
      tick();
      force_ack = 1'b0;
      check_eq("r_idle_ack_ignored", mem_req, 32'h0);
      check_eq("r_no_dmem_ack", dmem_ack, 32'h0);
      tick();
      check_eq("r_no_dmem_ack2", dmem_ack, 32'h0);
      check_eq("r_no_imem_ack", imem_ack, 32'h0);
      check_eq("r_still_idle", mem_req, 32'h0);

`ifdef RISCV_ARB_TIMEOUT_EN
      // Unanswered fetch completes after four busy cycles with a NOP.
      hold_ack  = 1'b1;
      imem_req  = 1'b1;
      imem_addr = 32'h108;
      tick();
      check_eq("t_err_start", err, 32'h0);
      tick();
      tick();
      tick();
      check_eq("t_no_ack_yet", imem_ack, 32'h0);
      tick();
      check_eq("t_ack", imem_ack, 32'h1);
      check_eq("t_nop", imem_rdata, 32'h0000_0013);
      check_eq("t_err_set", err, 32'h1);
      imem_req = 1'b0;
      drain();
      hold_ack = 1'b0;
      tick();
      check_eq("t_err_sticky", err, 32'h1);
      rst = 1'b1;
      #1;
      check_eq("t_err_cleared", err, 32'h0);
      tick();
      rst = 1'b0;
      tick();
`else
      check_eq("err_tied_low", err, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
